// File: rtl/skew_feed_scheduler_pkg.sv
// Shared accelerator types and defaults for the skewed column-feed path.
// Consumed by the scheduler, the column controller and the PE array.
package skew_feed_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int DEF_COL = 4;
  localparam int DEF_ROW = 9;
  localparam int DEF_DW  = 32;

  // Step counter must reach ROW+COL-2 without wrapping.
  function automatic int step_width(input int rows, input int cols);
    return $clog2(rows + cols);
  endfunction

endpackage

// File: rtl/skew_feed_scheduler_feed_lane.sv
// One column of the feed wavefront: read-window compare, valid register
// and output data mask for column C.
module feed_lane
  import skew_feed_scheduler_pkg::*;
#(
  parameter int C   = 0,
  parameter int ROW = DEF_ROW,
  parameter int DW  = DEF_DW,
  parameter int TW  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          run,
  input  logic [TW-1:0] t,
  input  logic          stall,
  input  logic [DW-1:0] fifo_data,
  output logic          need,
  output logic          read_enable,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic [31:0] t_wide;
  logic        lo_ok;
  logic        hi_ok;
  logic        valid_reg;

  assign t_wide = 32'(t);

  // Column 0 has no lower bound; avoid a tautological compare there.
  generate
    if (C == 0) begin : g_lo_first
      assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign lo_ok = (t_wide >= 32'(C));
    end
  endgenerate

  assign hi_ok       = (t_wide < 32'(C + ROW));
  assign need        = run & lo_ok & hi_ok;
  assign read_enable = need & ~stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= read_enable;
    end
  end

  assign valid = valid_reg;
  assign data  = valid_reg ? fifo_data : '0;

endmodule

// File: rtl/skew_feed_scheduler.sv
// Globally coordinated skewed read wavefront over COL column FIFOs.
// Any needed-but-empty FIFO freezes the whole wavefront for that cycle.
module skew_feed_scheduler
  import skew_feed_scheduler_pkg::*;
#(
  parameter int COL = DEF_COL,
  parameter int ROW = DEF_ROW,
  parameter int DW  = DEF_DW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [COL-1:0]    i_fifo_empty,
  input  logic [COL*DW-1:0] i_data,
  output logic [COL-1:0]    o_fifo_read_enable,
  output logic [COL-1:0]    o_valid,
  output logic [COL*DW-1:0] o_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int            TW     = step_width(ROW, COL);
  localparam logic [TW-1:0] T_LAST = TW'(ROW + COL - 2);

  sched_state_t  state_reg;
  sched_state_t  state_next;
  logic [TW-1:0] t_reg;
  logic [TW-1:0] t_next;
  logic [COL-1:0] need;
  logic          run;
  logic          stall;

  assign run   = (state_reg == RUN);
  assign stall = |(need & i_fifo_empty);

  generate
    for (genvar gi = 0; gi < COL; gi++) begin : g_lane
      feed_lane #(
        .C  (gi),
        .ROW(ROW),
        .DW (DW),
        .TW (TW)
      ) u_lane (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .run        (run),
        .t          (t_reg),
        .stall      (stall),
        .fifo_data  (i_data[gi*DW +: DW]),
        .need       (need[gi]),
        .read_enable(o_fifo_read_enable[gi]),
        .valid      (o_valid[gi]),
        .data       (o_data[gi*DW +: DW])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      t_reg     <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = RUN;
          t_next     = '0;
        end
      end
      RUN: begin
        // t only advances on cycles where the whole wavefront moved.
        if (!stall) begin
          if (t_reg == T_LAST) begin
            state_next = DRAIN;
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        t_next     = '0;
      end
    endcase
  end

  assign o_busy = (state_reg != IDLE);
  assign o_done = (state_reg == DRAIN);

endmodule

// File: tb/tb_skew_feed_scheduler.sv
// Randomized scoreboard bench for skew_feed_scheduler (COL=4, ROW=9) plus a
// COL=1/ROW=1 instance for the degenerate case.
module tb_skew_feed_scheduler;

  localparam int COL = 4;
  localparam int ROW = 9;
  localparam int DW  = 32;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [COL-1:0]    empty;
  logic [COL*DW-1:0] fdata;
  logic [COL-1:0]    rden;
  logic [COL-1:0]    valid;
  logic [COL*DW-1:0] odata;
  logic              busy;
  logic              done;

  skew_feed_scheduler #(.COL(COL), .ROW(ROW), .DW(DW)) u_dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_fifo_empty      (empty),
    .i_data            (fdata),
    .o_fifo_read_enable(rden),
    .o_valid           (valid),
    .o_data            (odata),
    .o_busy            (busy),
    .o_done            (done)
  );

  logic        d_rst;
  logic        d_start;
  logic [0:0]  d_empty;
  logic [31:0] d_data;
  logic [0:0]  d_rden;
  logic [0:0]  d_valid;
  logic [31:0] d_odata;
  logic        d_busy;
  logic        d_done;

  skew_feed_scheduler #(.COL(1), .ROW(1), .DW(32)) u_dut1 (
    .i_clk             (clk),
    .i_rst             (d_rst),
    .i_start           (d_start),
    .i_fifo_empty      (d_empty),
    .i_data            (d_data),
    .o_fifo_read_enable(d_rden),
    .o_valid           (d_valid),
    .o_data            (d_odata),
    .o_busy            (d_busy),
    .o_done            (d_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: abstract wavefront position and job bookkeeping.
  int             cyc = 0;
  int             m_state = S_IDLE;
  int             m_t = 0;
  logic [COL-1:0] m_prev_rd = '0;
  logic [COL-1:0] exp_rd;
  logic           m_stall;
  logic [DW-1:0]  expq [COL][$];
  logic [COL*DW-1:0] nxt_data = '0;
  logic [DW-1:0]  w;
  int             rel;
  int             js_cyc = 0;
  int             rd_cnt [COL];
  int             first_rd [COL];
  int             last_rd [COL];
  int             total_rd;
  int             done_rel;
  bit             rd_any [256];

  task automatic clear_stats();
    for (int c = 0; c < COL; c++) begin
      rd_cnt[c]   = 0;
      first_rd[c] = -1;
      last_rd[c]  = -1;
    end
    for (int i = 0; i < 256; i++) rd_any[i] = 1'b0;
    total_rd = 0;
    done_rel = -1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: the word for a read appears on i_data the cycle after.
  always @(posedge clk) begin
    #1;
    fdata = nxt_data;
  end

  always @(negedge clk) begin
    // Column c consumes word (t - c) while the wavefront covers it.
    exp_rd  = '0;
    m_stall = 1'b0;
    if (m_state == S_RUN) begin
      for (int c = 0; c < COL; c++)
        if (m_t - c >= 0 && m_t - c < ROW) exp_rd[c] = 1'b1;
      m_stall = |(exp_rd & empty);
      if (m_stall) exp_rd = '0;
    end
    check("rden", 64'(rden), 64'(exp_rd));
    check("valid", 64'(valid), 64'(m_prev_rd));
    check("busy", 64'(busy), 64'(m_state != S_IDLE));
    check("done", 64'(done), 64'(m_state == S_DRAIN));

    // Scoreboard pop, driven by what the DUT presents.
    for (int c = 0; c < COL; c++) begin
      if (valid[c]) begin
        if (expq[c].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow col %0d: got valid data %0h, expected no word", c, odata[c*DW +: DW]);
        end else begin
          w = expq[c].pop_front();
          check($sformatf("data col%0d", c), 64'(odata[c*DW +: DW]), 64'(w));
        end
      end else begin
        check($sformatf("mask col%0d", c), 64'(odata[c*DW +: DW]), 64'd0);
      end
    end

    rel = cyc - js_cyc;
    for (int c = 0; c < COL; c++) begin
      if (rden[c]) begin
        rd_cnt[c]++;
        total_rd++;
        if (first_rd[c] < 0) first_rd[c] = rel;
        last_rd[c] = rel;
      end
    end
    if (|rden && rel >= 0 && rel < 256) rd_any[rel] = 1'b1;
    if (done) done_rel = rel;

    // FIFO side: reads issued now produce a fresh word next cycle.
    for (int c = 0; c < COL; c++) begin
      w = $urandom;
      nxt_data[c*DW +: DW] = w;
      if (rden[c] && !rst) expq[c].push_back(w);
    end
    if (rst) for (int c = 0; c < COL; c++) expq[c].delete();

    if (rst) begin
      m_state   = S_IDLE;
      m_t       = 0;
      m_prev_rd = '0;
    end else begin
      m_prev_rd = exp_rd;
      case (m_state)
        S_IDLE: if (start) begin
          m_state = S_RUN;
          m_t     = 0;
          js_cyc  = cyc;
          clear_stats();
        end
        S_RUN: if (!m_stall) begin
          if (m_t == ROW + COL - 2) m_state = S_DRAIN;
          else m_t++;
        end
        default: m_state = S_IDLE;
      endcase
    end
  end

  // Empty pattern per relative cycle r for each scenario.
  function automatic logic [COL-1:0] pat(input int mode, input int r);
    logic [COL-1:0] p;
    p = '0;
    case (mode)
      1: if (r >= 6 && r <= 8) p[2] = 1'b1;
      2: if (r >= 1 && r <= 3) p[3] = 1'b1;
      3: for (int c = 0; c < COL; c++) p[c] = ($urandom_range(0, 7) == 0);
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      empty = pat(3, 0);
    end
  endtask

  // Modes: 0 nominal, 1 stall, 2 empty outside window, 3 random,
  // 4 extra starts in RUN/DRAIN, 5 reset mid-job.
  task automatic run_job(input int mode);
    int r;
    bit finished;
    start    = 1'b1;
    empty    = pat(mode, 0);
    finished = 1'b0;
    for (r = 1; r < 200 && !finished; r++) begin
      @(posedge clk);
      #1;
      start = (mode == 4) && (r == 3 || r == 13);
      empty = pat(mode, r);
      if (mode == 5) rst = (r == 7);
      if (m_state == S_IDLE && r > 2) finished = 1'b1;
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_timeout mode %0d: job still active after %0d cycles, expected completion", mode, r);
    end
  endtask

  task automatic check_nominal(input string tag);
    check({tag, " done_cycle"}, 64'(done_rel), 64'(ROW + COL));
    check({tag, " rd0_first"}, 64'(first_rd[0]), 64'd1);
    check({tag, " rd0_last"}, 64'(last_rd[0]), 64'(ROW));
    check({tag, " rd3_first"}, 64'(first_rd[3]), 64'd4);
    check({tag, " rd3_last"}, 64'(last_rd[3]), 64'(3 + ROW));
    check({tag, " total_reads"}, 64'(total_rd), 64'(COL * ROW));
  endtask

  task automatic check_counts(input string tag);
    for (int c = 0; c < COL; c++)
      check($sformatf("%s reads col%0d", tag, c), 64'(rd_cnt[c]), 64'(ROW));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    empty   = '0;
    fdata   = '0;
    d_rst   = 1'b1;
    d_start = 1'b0;
    d_empty = 1'b0;
    d_data  = 32'hA5A5_0001;
    clear_stats();

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(4);

    run_job(0);
    check_nominal("nominal");
    idle_cycles(3);

    run_job(1);
    check("stall done_cycle", 64'(done_rel), 64'(ROW + COL + 3));
    for (int i = 6; i <= 8; i++)
      check($sformatf("stall no_read cyc%0d", i), 64'(rd_any[i]), 64'd0);
    check_counts("stall");
    idle_cycles(3);

    run_job(2);
    check_nominal("outside_window");
    idle_cycles(2);

    run_job(4);
    check_nominal("extra_start");
    idle_cycles(4);

    run_job(5);
    idle_cycles(2);
    run_job(0);
    check_nominal("after_reset");
    idle_cycles(2);

    for (int j = 0; j < 6; j++) begin
      run_job(3);
      check_counts($sformatf("random%0d", j));
      idle_cycles($urandom_range(1, 3));
    end

    // Degenerate single-column, single-word job.
    @(posedge clk);
    #1;
    d_rst   = 1'b0;
    @(posedge clk);
    #1;
    d_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("deg rden k%0d", k), 64'(d_rden), 64'(k == 1));
      check($sformatf("deg valid k%0d", k), 64'(d_valid), 64'(k == 2));
      check($sformatf("deg done k%0d", k), 64'(d_done), 64'(k == 2));
      check($sformatf("deg busy k%0d", k), 64'(d_busy), 64'(k == 1 || k == 2));
      check($sformatf("deg data k%0d", k), 64'(d_odata), (k == 2) ? 64'(d_data) : 64'd0);
      @(posedge clk);
      #1;
      d_start = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
